// File: rtl/sudoku_pkg.sv
// State encoding and parameter helpers shared by the sudoku game controller.
package sudoku_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        GEN_RAND   = 4'd1,
        SET_BOARD  = 4'd2,
        SET_DIFF   = 4'd3,
        CHOOSE_ROW = 4'd4,
        CHOOSE_COL = 4'd5,
        CHOOSE_VAL = 4'd6,
        CHECKING   = 4'd7,
        WIN        = 4'd8,
        LOSE       = 4'd9,
        NEW_GAME   = 4'd10
    } gameState_e;

    function automatic bit boardSizeLegal(input int n);
        return (n == 4) || (n == 9) || (n == 16);
    endfunction

    // A zero budget still needs a one-bit counter.
    function automatic int moveWidth(input int maxMoves);
        return (maxMoves == 0) ? 1 : $clog2(maxMoves + 1);
    endfunction

endpackage

// File: rtl/sudoku_game_ctrl_btn_release_det.sv
// Registers a debounced button once and flags the cycle in which it falls.
module btn_release_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rel_o
);

    logic btn_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign rel_o = btn_q & ~btn_i;

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Game-control FSM for an N x N sudoku: drives generator/checker handshakes,
// latches the player's row/col/value choices and enforces the move budget.
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int BOARD_N   = 4,
    parameter int SEL_W     = $clog2(BOARD_N + 1),
    parameter int MAX_MOVES = 32,
    parameter int MOVE_W    = moveWidth(MAX_MOVES)
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              new_game,
    input  logic              enter,
    input  logic              back,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              gen_done,
    input  logic              check_done,
    input  logic              solved,
    output logic [3:0]        state,
    output logic              gen_req,
    output logic              check_req,
    output logic              set_board_flag,
    output logic              set_diff_flag,
    output logic              row_flag,
    output logic              col_flag,
    output logic              val_flag,
    output logic [SEL_W-1:0]  row,
    output logic [SEL_W-1:0]  col,
    output logic [SEL_W-1:0]  val,
    output logic [SEL_W-1:0]  diff,
    output logic [MOVE_W-1:0] move_count,
    output logic              err_pulse
);

    if (!boardSizeLegal(BOARD_N)) begin : g_bad_board_n
        $error("sudoku_game_ctrl: BOARD_N must be 4, 9 or 16");
    end

    gameState_e        state_q, state_d;
    logic              genReq_q, checkReq_q, err_q;
    logic              setBoard_q, setDiff_q, rowFlag_q, colFlag_q, valFlag_q;
    logic [SEL_W-1:0]  row_q, col_q, val_q, diff_q;
    logic [MOVE_W-1:0] moveCount_q;

    logic entRelRaw, bkRel, entRel;
    logic coordOk, valueOk, budgetSpent;
    logic errDet, loadDiff, loadRow, loadCol, loadVal;

    btn_release_det u_enter_det (
        .clk_i  (clka),
        .rst_ni (restart_n),
        .btn_i  (enter),
        .rel_o  (entRelRaw)
    );

    btn_release_det u_back_det (
        .clk_i  (clka),
        .rst_ni (restart_n),
        .btn_i  (back),
        .rel_o  (bkRel)
    );

    // A simultaneous back release swallows the enter release.
    assign entRel      = entRelRaw & ~bkRel;
    assign coordOk     = sel_in < SEL_W'(BOARD_N);
    assign valueOk     = (sel_in != '0) && (sel_in <= SEL_W'(BOARD_N));
    assign budgetSpent = (MAX_MOVES != 0) && (moveCount_q == MOVE_W'(MAX_MOVES));

    always_comb begin
        state_d  = state_q;
        errDet   = 1'b0;
        loadDiff = 1'b0;
        loadRow  = 1'b0;
        loadCol  = 1'b0;
        loadVal  = 1'b0;
        if (new_game) begin
            state_d = NEW_GAME;
        end else begin
            case (state_q)
                IDLE:      state_d = GEN_RAND;
                NEW_GAME:  state_d = GEN_RAND;
                GEN_RAND:  if (gen_done) state_d = SET_BOARD;
                SET_BOARD: if (entRel) state_d = SET_DIFF;
                SET_DIFF: begin
                    if (entRel) begin
                        loadDiff = 1'b1;
                        state_d  = CHOOSE_ROW;
                    end
                end
                CHOOSE_ROW: begin
                    if (entRel && coordOk) begin
                        loadRow = 1'b1;
                        state_d = CHOOSE_COL;
                    end else if (entRel) begin
                        errDet = 1'b1;
                    end
                end
                CHOOSE_COL: begin
                    if (bkRel) begin
                        state_d = CHOOSE_ROW;
                    end else if (entRel && coordOk) begin
                        loadCol = 1'b1;
                        state_d = CHOOSE_VAL;
                    end else if (entRel) begin
                        errDet = 1'b1;
                    end
                end
                CHOOSE_VAL: begin
                    if (bkRel) begin
                        state_d = CHOOSE_COL;
                    end else if (entRel && valueOk) begin
                        loadVal = 1'b1;
                        state_d = CHECKING;
                    end else if (entRel) begin
                        errDet = 1'b1;
                    end
                end
                CHECKING: begin
                    if (check_done) begin
                        if (solved)           state_d = WIN;
                        else if (budgetSpent) state_d = LOSE;
                        else                  state_d = CHOOSE_ROW;
                    end
                end
                WIN:     state_d = WIN;
                LOSE:    state_d = LOSE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q     <= IDLE;
            genReq_q    <= 1'b0;
            checkReq_q  <= 1'b0;
            setBoard_q  <= 1'b0;
            setDiff_q   <= 1'b0;
            rowFlag_q   <= 1'b0;
            colFlag_q   <= 1'b0;
            valFlag_q   <= 1'b0;
            err_q       <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            val_q       <= '0;
            diff_q      <= '0;
            moveCount_q <= '0;
        end else begin
            state_q    <= state_d;
            genReq_q   <= (state_d == GEN_RAND);
            checkReq_q <= (state_d == CHECKING);
            setBoard_q <= (state_d == SET_BOARD);
            setDiff_q  <= (state_d == SET_DIFF);
            rowFlag_q  <= (state_d == CHOOSE_ROW);
            colFlag_q  <= (state_d == CHOOSE_COL);
            valFlag_q  <= (state_d == CHOOSE_VAL);
            err_q      <= errDet;
            if (loadDiff) diff_q <= sel_in;
            if (state_d == NEW_GAME) begin
                row_q       <= '0;
                col_q       <= '0;
                val_q       <= '0;
                moveCount_q <= '0;
            end else begin
                if (loadRow) row_q <= sel_in;
                if (loadCol) col_q <= sel_in;
                if (loadVal) begin
                    val_q <= sel_in;
                    if (moveCount_q != {MOVE_W{1'b1}}) begin
                        moveCount_q <= moveCount_q + MOVE_W'(1);
                    end
                end
            end
        end
    end

    assign state          = state_q;
    assign gen_req        = genReq_q;
    assign check_req      = checkReq_q;
    assign set_board_flag = setBoard_q;
    assign set_diff_flag  = setDiff_q;
    assign row_flag       = rowFlag_q;
    assign col_flag       = colFlag_q;
    assign val_flag       = valFlag_q;
    assign row            = row_q;
    assign col            = col_q;
    assign val            = val_q;
    assign diff           = diff_q;
    assign move_count     = moveCount_q;
    assign err_pulse      = err_q;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Directed bench for sudoku_game_ctrl (9x9 board, two-move budget) with a
// behavioural model compared every cycle plus literal spot checks.
module tb_sudoku_game_ctrl;

    localparam int BOARD_N   = 9;
    localparam int MAX_MOVES = 2;
    localparam int SEL_W     = 4;
    localparam int MOVE_W    = 2;
    localparam int MOVE_SAT  = (1 << MOVE_W) - 1;

    localparam int S_IDLE = 0, S_GEN = 1, S_BOARD = 2, S_DIFF = 3, S_ROW = 4, S_COL = 5;
    localparam int S_VAL = 6, S_CHECK = 7, S_WIN = 8, S_LOSE = 9, S_NEW = 10;

    logic              clka = 1'b0;
    logic              restart_n = 1'b1;
    logic              new_game = 1'b0, enter = 1'b0, back = 1'b0;
    logic [SEL_W-1:0]  sel_in = '0;
    logic              gen_done = 1'b0, check_done = 1'b0, solved = 1'b0;
    logic [3:0]        state;
    logic              gen_req, check_req, set_board_flag, set_diff_flag;
    logic              row_flag, col_flag, val_flag, err_pulse;
    logic [SEL_W-1:0]  row, col, val, diff;
    logic [MOVE_W-1:0] move_count;

    int checks = 0;
    int failures = 0;
    bit compareOn = 1'b0;

    sudoku_game_ctrl #(
        .BOARD_N   (BOARD_N),
        .MAX_MOVES (MAX_MOVES)
    ) dut (
        .clka           (clka),
        .restart_n      (restart_n),
        .new_game       (new_game),
        .enter          (enter),
        .back           (back),
        .sel_in         (sel_in),
        .gen_done       (gen_done),
        .check_done     (check_done),
        .solved         (solved),
        .state          (state),
        .gen_req        (gen_req),
        .check_req      (check_req),
        .set_board_flag (set_board_flag),
        .set_diff_flag  (set_diff_flag),
        .row_flag       (row_flag),
        .col_flag       (col_flag),
        .val_flag       (val_flag),
        .row            (row),
        .col            (col),
        .val            (val),
        .diff           (diff),
        .move_count     (move_count),
        .err_pulse      (err_pulse)
    );

    always #5 clka = ~clka;

    // Behavioural model of the game rules
    int mState, mRow, mCol, mVal, mDiff, mMoves;
    bit mErr, mEntPrev, mBkPrev;

    always @(posedge clka or negedge restart_n) begin : model
        bit er, br;
        int nxt;
        if (!restart_n) begin
            mState = S_IDLE; mRow = 0; mCol = 0; mVal = 0; mDiff = 0; mMoves = 0;
            mErr = 0; mEntPrev = 0; mBkPrev = 0;
        end else begin
            br = mBkPrev && !back;
            er = mEntPrev && !enter && !br;
            mEntPrev = enter;
            mBkPrev = back;
            mErr = 0;
            nxt = mState;
            if (new_game) nxt = S_NEW;
            else if (mState == S_IDLE || mState == S_NEW) nxt = S_GEN;
            else if (mState == S_GEN) begin
                if (gen_done) nxt = S_BOARD;
            end else if (mState == S_BOARD) begin
                if (er) nxt = S_DIFF;
            end else if (mState == S_DIFF) begin
                if (er) begin mDiff = int'(sel_in); nxt = S_ROW; end
            end else if (mState == S_ROW || mState == S_COL) begin
                if (br && mState == S_COL) nxt = S_ROW;
                else if (er && int'(sel_in) < BOARD_N) begin
                    if (mState == S_ROW) begin mRow = int'(sel_in); nxt = S_COL; end
                    else begin mCol = int'(sel_in); nxt = S_VAL; end
                end else if (er) mErr = 1;
            end else if (mState == S_VAL) begin
                if (br) nxt = S_COL;
                else if (er && int'(sel_in) >= 1 && int'(sel_in) <= BOARD_N) begin
                    mVal = int'(sel_in);
                    mMoves = (mMoves >= MOVE_SAT) ? MOVE_SAT : mMoves + 1;
                    nxt = S_CHECK;
                end else if (er) mErr = 1;
            end else if (mState == S_CHECK) begin
                if (check_done) begin
                    if (solved) nxt = S_WIN;
                    else if (MAX_MOVES != 0 && mMoves == MAX_MOVES) nxt = S_LOSE;
                    else nxt = S_ROW;
                end
            end
            if (nxt == S_NEW) begin
                mRow = 0; mCol = 0; mVal = 0; mMoves = 0;
            end
            mState = nxt;
        end
    end

    wire [29:0] dutVec = {state, gen_req, check_req, set_board_flag, set_diff_flag,
                          row_flag, col_flag, val_flag, row, col, val, diff, move_count, err_pulse};

    function automatic logic [29:0] modelVec();
        return {4'(mState), mState == S_GEN, mState == S_CHECK, mState == S_BOARD,
                mState == S_DIFF, mState == S_ROW, mState == S_COL, mState == S_VAL,
                4'(mRow), 4'(mCol), 4'(mVal), 4'(mDiff), 2'(mMoves), mErr};
    endfunction

    always @(negedge clka) begin
        if (compareOn) begin
            checks++;
            if (dutVec !== modelVec()) begin
                failures++;
                $display("[TB] FAIL model_compare t=%0t: dut=%h model=%h", $time, dutVec, modelVec());
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit ng, input bit en, input bit bk, input logic [SEL_W-1:0] sel,
                                 input bit gd, input bit cd, input bit sv);
        new_game = ng; enter = en; back = bk; sel_in = sel;
        gen_done = gd; check_done = cd; solved = sv;
        @(negedge clka);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, sel_in, 0, 0, 0);
    endtask

    task automatic pressRelease(input logic [SEL_W-1:0] sel);
        applyStimulus(0, 1, 0, sel, 0, 0, 0);
        applyStimulus(0, 0, 0, sel, 0, 0, 0);
    endtask

    task automatic startToRow(input logic [SEL_W-1:0] d);
        applyStimulus(0, 0, 0, sel_in, 1, 0, 0);
        pressRelease(0);
        pressRelease(d);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int genHigh;
        #1 restart_n = 1'b0;
        @(negedge clka);
        compareOn = 1'b1;
        @(negedge clka);
        checkOutput("reset_all_zero", 32'(dutVec), 0);
        restart_n = 1'b1;
        checkOutput("idle_after_release", 32'(state), 0);

        genHigh = 0;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            genHigh += int'(gen_req);
        end
        checkOutput("gen_rand_state", 32'(state), 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        genHigh += int'(gen_req);
        checkOutput("gen_req_cycles", 32'(genHigh), 3);
        checkOutput("set_board_state", 32'(state), 2);

        pressRelease(0);
        checkOutput("set_diff_state", 32'(state), 3);
        pressRelease(5);
        checkOutput("diff_latched", 32'(diff), 5);
        checkOutput("choose_row_state", 32'(state), 4);

        pressRelease(12);
        checkOutput("row_reject_err", 32'(err_pulse), 1);
        checkOutput("row_reject_state", 32'(state), 4);
        idleCycle();
        checkOutput("err_one_cycle", 32'(err_pulse), 0);
        pressRelease(9);
        checkOutput("row_eq_n_reject", 32'(err_pulse), 1);
        pressRelease(2);
        checkOutput("row_latched", 32'(row), 2);
        checkOutput("choose_col_state", 32'(state), 5);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3, 0, 0, 0);
        checkOutput("held_enter_no_event", 32'(state), 5);
        applyStimulus(0, 0, 0, 3, 0, 0, 0);
        checkOutput("col_latched", 32'(col), 3);
        checkOutput("choose_val_state", 32'(state), 6);

        applyStimulus(0, 1, 1, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 4, 0, 0, 0);
        checkOutput("both_release_state", 32'(state), 5);
        checkOutput("both_release_val", 32'(val), 0);
        checkOutput("both_release_moves", 32'(move_count), 0);

        applyStimulus(0, 0, 1, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 4, 0, 0, 0);
        checkOutput("back_to_row", 32'(state), 4);
        checkOutput("back_keeps_row", 32'(row), 2);
        pressRelease(2);
        pressRelease(3);

        pressRelease(0);
        checkOutput("val_zero_reject", 32'(err_pulse), 1);
        pressRelease(10);
        checkOutput("val_over_n_reject", 32'(state), 6);
        pressRelease(9);
        checkOutput("val_n_accepted", 32'(val), 9);
        checkOutput("move_count_one", 32'(move_count), 1);
        checkOutput("check_req_high", 32'(check_req), 1);
        idleCycle();
        applyStimulus(0, 0, 0, 9, 0, 1, 0);
        checkOutput("wrong_move_row", 32'(state), 4);

        pressRelease(1);
        pressRelease(1);
        pressRelease(4);
        checkOutput("move_count_two", 32'(move_count), 2);
        applyStimulus(0, 0, 0, 4, 0, 1, 0);
        checkOutput("lose_state", 32'(state), 9);
        pressRelease(1);
        checkOutput("lose_terminal", 32'(state), 9);

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("new_game_state", 32'(state), 10);
        checkOutput("new_game_moves", 32'(move_count), 0);
        checkOutput("new_game_row", 32'(row), 0);
        checkOutput("diff_retained", 32'(diff), 5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("new_game_held", 32'(state), 10);
        idleCycle();
        checkOutput("new_game_to_gen", 32'(state), 1);

        startToRow(7);
        checkOutput("diff_relatched", 32'(diff), 7);
        pressRelease(0);
        pressRelease(0);
        pressRelease(1);
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        checkOutput("gen_done_ignored", 32'(state), 7);
        applyStimulus(0, 0, 0, 1, 0, 1, 1);
        checkOutput("win_state", 32'(state), 8);
        pressRelease(1);
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        checkOutput("win_terminal", 32'(state), 8);

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idleCycle();
        startToRow(7);
        pressRelease(0);
        pressRelease(0);
        pressRelease(2);
        checkOutput("checking_again", 32'(state), 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("ng_drops_check_req", 32'(check_req), 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("late_check_done_ignored", 32'(state), 1);

        startToRow(7);
        pressRelease(0);
        pressRelease(0);
        pressRelease(3);
        checkOutput("checking_before_reset", 32'(state), 7);
        #2 restart_n = 1'b0;
        #1 checkOutput("async_reset_outputs", 32'(dutVec), 0);
        @(negedge clka);
        checkOutput("held_reset_state", 32'(state), 0);
        restart_n = 1'b1;
        idleCycle();
        checkOutput("gen_after_reset", 32'(state), 1);
        idleCycle();

        compareOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
